iob_pcie_chnl_ctrl: RTL

Transaction sequencer for one RIFFA PCIe channel, running in the PCIe user clock domain. It runs the RX handshake: detects the request, acknowledges it, and counts beats into a receive buffer. It also runs the TX handshake: raises the request, counts beats out of a transmit buffer, and drops the request. It sits between the RIFFA channel pins and the RX/TX clock-crossing FIFOs of the PCIe core, and replaces software bit-banging of ACK/REN/TX.

---
 rtl/iob_pcie_chnl_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/iob_pcie_chnl_ctrl.sv
// RIFFA PCIe channel sequencer: RX/TX handshakes and beat counting between channel pins and buffers.
// Optional watchdog enabled by defining IOB_PCIE_CHNL_CTRL_TIMEOUT_EN.
module iob_pcie_chnl_ctrl #(
  parameter int DATA_W           = 32,
  parameter int C_PCI_DATA_WIDTH = 64,
  parameter int TIMEOUT_W        = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        PCIE_CHNL_RX_i,
  input  logic [DATA_W-1:0]           PCIE_CHNL_RX_LEN_i,
  input  logic [C_PCI_DATA_WIDTH-1:0] PCIE_CHNL_RX_DATA_i,
  input  logic                        PCIE_CHNL_RX_DATA_VALID_i,
  output logic                        PCIE_CHNL_RX_ACK_o,
  output logic                        PCIE_CHNL_RX_DATA_REN_o,
  input  logic                        rx_buf_full_i,
  output logic                        rx_buf_wen_o,
  output logic [C_PCI_DATA_WIDTH-1:0] rx_buf_wdata_o,
  output logic                        PCIE_CHNL_TX_o,
  output logic                        PCIE_CHNL_TX_LAST_o,
  output logic [DATA_W-1:0]           PCIE_CHNL_TX_LEN_o,
  output logic [DATA_W-2:0]           PCIE_CHNL_TX_OFF_o,
  output logic [C_PCI_DATA_WIDTH-1:0] PCIE_CHNL_TX_DATA_o,
  output logic                        PCIE_CHNL_TX_DATA_VALID_o,
  input  logic                        PCIE_CHNL_TX_DATA_REN_i,
  input  logic                        PCIE_CHNL_TX_ACK_i,
  input  logic                        tx_buf_empty_i,
  input  logic [C_PCI_DATA_WIDTH-1:0] tx_buf_rdata_i,
  output logic                        tx_buf_ren_o,
  input  logic                        tx_start_i,
  input  logic [DATA_W-1:0]           tx_len_i,
  input  logic                        tx_last_i,
  output logic                        rx_busy_o,
  output logic                        tx_busy_o,
  output logic                        rx_done_o,
  output logic                        tx_done_o,
  output logic [DATA_W-1:0]           rx_len_o,
  output logic                        tx_acked_o,
  output logic                        err_o
);

  typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_DATA, RX_WAIT} rx_state_t;
  typedef enum logic {TX_IDLE, TX_DATA} tx_state_t;

  rx_state_t         rx_state_q, rx_state_d;
  tx_state_t         tx_state_q, tx_state_d;
  logic [DATA_W-1:0] rx_len_q, rx_len_d, rx_cnt_q, rx_cnt_d;
  logic [DATA_W-1:0] tx_len_q, tx_len_d, tx_cnt_q, tx_cnt_d;
  logic              tx_last_q, tx_last_d, tx_acked_q, tx_acked_d;
  logic              rx_ack_q, rx_done_q, rx_done_d, tx_done_q, tx_done_d, err_q, err_d;
  logic [DATA_W:0]   rx_beats, tx_beats;
  logic              rx_ren, rx_wen, rx_final, rx_abort, rx_to;
  logic              tx_valid, tx_pop, tx_final, tx_to;

  // Beat counts carry one extra bit so a length of all-ones cannot wrap.
  assign rx_beats = ({1'b0, rx_len_q} + (DATA_W+1)'(1)) >> 1;
  assign tx_beats = ({1'b0, tx_len_q} + (DATA_W+1)'(1)) >> 1;

  // Data phase waits out the ACK cycle so the first REN lands one cycle after ACK.
  assign rx_ren   = (rx_state_q == RX_DATA) && !rx_ack_q && !rx_buf_full_i;
  assign rx_wen   = rx_ren && PCIE_CHNL_RX_DATA_VALID_i;
  assign rx_final = rx_wen && (({1'b0, rx_cnt_q} + (DATA_W+1)'(1)) == rx_beats);
  assign rx_abort = (rx_state_q == RX_DATA) && !PCIE_CHNL_RX_i && !rx_final;

  assign tx_valid = (tx_state_q == TX_DATA) && !tx_buf_empty_i;
  assign tx_pop   = tx_valid && PCIE_CHNL_TX_DATA_REN_i;
  assign tx_final = tx_pop && (({1'b0, tx_cnt_q} + (DATA_W+1)'(1)) == tx_beats);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_len_d   = rx_len_q;
    rx_cnt_d   = rx_cnt_q;
    rx_done_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (PCIE_CHNL_RX_i) begin
        rx_len_d   = PCIE_CHNL_RX_LEN_i;
        rx_cnt_d   = '0;
        rx_state_d = RX_ACK;
      end
      RX_ACK:  rx_state_d = (rx_beats == '0) ? RX_WAIT : RX_DATA;
      RX_DATA: begin
        if (rx_to || rx_abort) begin
          rx_state_d = RX_IDLE;
        end else if (rx_final) begin
          rx_done_d  = 1'b1;
          rx_state_d = RX_WAIT;
        end else if (rx_wen) begin
          rx_cnt_d = rx_cnt_q + DATA_W'(1);
        end
      end
      RX_WAIT: if (!PCIE_CHNL_RX_i) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_len_d   = tx_len_q;
    tx_last_d  = tx_last_q;
    tx_cnt_d   = tx_cnt_q;
    tx_acked_d = tx_acked_q;
    tx_done_d  = 1'b0;
    case (tx_state_q)
      TX_IDLE: if (tx_start_i) begin
        tx_acked_d = 1'b0;
        if (tx_len_i != '0) begin
          tx_len_d   = tx_len_i;
          tx_last_d  = tx_last_i;
          tx_cnt_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_done_d = 1'b1;
        end
      end
      TX_DATA: begin
        if (PCIE_CHNL_TX_ACK_i) tx_acked_d = 1'b1;
        if (tx_to) begin
          tx_state_d = TX_IDLE;
        end else if (tx_final) begin
          tx_done_d  = 1'b1;
          tx_state_d = TX_IDLE;
        end else if (tx_pop) begin
          tx_cnt_d = tx_cnt_q + DATA_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign err_d = rx_abort || ((rx_state_q == RX_DATA) && rx_to) || ((tx_state_q == TX_DATA) && tx_to);

`ifdef IOB_PCIE_CHNL_CTRL_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] rx_wd_q, tx_wd_q;

  // Watchdogs only run in the data phases and restart on any progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wd_q <= '0;
      tx_wd_q <= '0;
    end else begin
      if (rx_state_q != RX_DATA || rx_state_d != rx_state_q || rx_wen) rx_wd_q <= '0;
      else rx_wd_q <= rx_wd_q + TIMEOUT_W'(1);
      if (tx_state_q != TX_DATA || tx_state_d != tx_state_q || tx_pop) tx_wd_q <= '0;
      else tx_wd_q <= tx_wd_q + TIMEOUT_W'(1);
    end
  end

  assign rx_to = (rx_state_q == RX_DATA) && (&rx_wd_q);
  assign tx_to = (tx_state_q == TX_DATA) && (&tx_wd_q);
`else
  assign rx_to = 1'b0;
  assign tx_to = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      tx_state_q <= TX_IDLE;
      rx_len_q   <= '0;
      rx_cnt_q   <= '0;
      tx_len_q   <= '0;
      tx_cnt_q   <= '0;
      tx_last_q  <= 1'b0;
      tx_acked_q <= 1'b0;
      rx_ack_q   <= 1'b0;
      rx_done_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      rx_len_q   <= rx_len_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_len_q   <= tx_len_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_last_q  <= tx_last_d;
      tx_acked_q <= tx_acked_d;
      rx_ack_q   <= (rx_state_q == RX_ACK);
      rx_done_q  <= rx_done_d;
      tx_done_q  <= tx_done_d;
      err_q      <= err_d;
    end
  end

  assign PCIE_CHNL_RX_ACK_o        = rx_ack_q;
  assign PCIE_CHNL_RX_DATA_REN_o   = rx_ren;
  assign rx_buf_wen_o              = rx_wen;
  assign rx_buf_wdata_o            = (rx_state_q == RX_DATA) ? PCIE_CHNL_RX_DATA_i : '0;
  assign PCIE_CHNL_TX_o            = (tx_state_q == TX_DATA);
  assign PCIE_CHNL_TX_LAST_o       = tx_last_q;
  assign PCIE_CHNL_TX_LEN_o        = tx_len_q;
  assign PCIE_CHNL_TX_OFF_o        = '0;
  assign PCIE_CHNL_TX_DATA_o       = (tx_state_q == TX_DATA) ? tx_buf_rdata_i : '0;
  assign PCIE_CHNL_TX_DATA_VALID_o = tx_valid;
  assign tx_buf_ren_o              = tx_pop;
  assign rx_busy_o                 = (rx_state_q != RX_IDLE);
  assign tx_busy_o                 = (tx_state_q == TX_DATA);
  assign rx_done_o                 = rx_done_q;
  assign tx_done_o                 = tx_done_q;
  assign rx_len_o                  = rx_len_q;
  assign tx_acked_o                = tx_acked_q;
  assign err_o                     = err_q;

endmodule
